// File: rtl/fifo_pkg.sv
// Shared types for the FIFO read controller: FSM states, skid depth and the
// skid pointer helper.
package fifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int unsigned SKID_DEPTH = 3;
  localparam int unsigned OCC_W      = 2;

  function automatic logic [OCC_W-1:0] ptr_inc(input logic [OCC_W-1:0] p);
    return (p == OCC_W'(SKID_DEPTH - 1)) ? '0 : p + OCC_W'(1);
  endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// 3-entry in-order skid buffer between the FIFO read port and the downstream
// valid/ready interface.
module fifo_rd_skid
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             nonempty,
  output logic [OCC_W-1:0] occupancy
);

  logic [WIDTH-1:0] mem_q [SKID_DEPTH];
  logic [WIDTH-1:0] mem_d [SKID_DEPTH];
  logic [OCC_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             do_pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    do_pop   = pop && (occ_q != '0);
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    // Simultaneous push and pop leaves occupancy unchanged.
    case ({push, do_pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < SKID_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign head      = mem_q[rd_ptr_q];
  assign nonempty  = (occ_q != '0);
  assign occupancy = occ_q;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Burst read controller: drains burst_len_i words from a FIFO into a skid
// buffer feeding a valid/ready port. FIFO_RD_CTRL_TIMEOUT_EN adds an empty-stall abort.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned LEN_W   = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [LEN_W-1:0] burst_len_i,
  input  logic             fifo_empty_i,
  input  logic [WIDTH-1:0] fifo_rdata_i,
  output logic             fifo_rd_en_o,
  output logic             m_valid_o,
  output logic [WIDTH-1:0] m_data_o,
  input  logic             m_ready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [LEN_W-1:0] count_o,
  output logic             timeout_o
);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] issued_q, issued_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic             inflight_q;
  logic             rd_en;
  logic             xfer;
  logic             nonempty;
  logic [OCC_W-1:0] occ;
  logic             tmo_hit;

  // Reads are throttled on buffered plus in-flight words so the skid never overflows.
  assign rd_en = (state_q == READ) && !fifo_empty_i && (issued_q < len_q) &&
                 (({1'b0, occ} + {2'b00, inflight_q}) < 3'(SKID_DEPTH));
  assign xfer  = nonempty && m_ready_i;

`ifdef FIFO_RD_CTRL_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             timeout_q, timeout_d;

  always_comb begin
    tmo_d   = tmo_q;
    tmo_hit = 1'b0;
    if (state_q == READ) begin
      if (rd_en) begin
        tmo_d = '0;
      end else if (fifo_empty_i && (issued_q < len_q)) begin
        tmo_d = tmo_q + TMO_W'(1);
      end
      tmo_hit = (tmo_d == TMO_W'(TIMEOUT));
    end else begin
      tmo_d = '0;
    end
  end

  always_comb begin
    timeout_d = timeout_q;
    if (state_q == IDLE && start_i) begin
      timeout_d = 1'b0;
    end else if (state_q == READ && tmo_hit && (issued_d != len_q)) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tmo_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_q     <= tmo_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign tmo_hit   = 1'b0;
  assign timeout_o = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    issued_d = issued_q;
    count_d  = count_q;
    if (xfer) begin
      count_d = count_q + LEN_W'(1);
    end
    case (state_q)
      IDLE: begin
        if (start_i) begin
          len_d    = burst_len_i;
          issued_d = '0;
          count_d  = '0;
          state_d  = (burst_len_i == '0) ? DONE : READ;
        end
      end
      READ: begin
        if (rd_en) begin
          issued_d = issued_q + LEN_W'(1);
        end
        if (issued_d == len_q || tmo_hit) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!nonempty && !inflight_q) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      len_q      <= '0;
      issued_q   <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      count_q    <= count_d;
      inflight_q <= rd_en;
    end
  end

  fifo_rd_skid #(
    .WIDTH(WIDTH)
  ) u_skid (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push     (inflight_q),
    .push_data(fifo_rdata_i),
    .pop      (xfer),
    .head     (m_data_o),
    .nonempty (nonempty),
    .occupancy(occ)
  );

  assign fifo_rd_en_o = rd_en;
  assign m_valid_o    = nonempty;
  assign busy_o       = (state_q == READ) || (state_q == DRAIN);
  assign done_o       = (state_q == DONE);
  assign count_o      = count_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl: synchronous-read FIFO model, word
// scoreboard, vector table and hand-written corner sequences.
module tb_fifo_rd_ctrl;

`ifdef FIFO_RD_CTRL_TIMEOUT_EN
  localparam int unsigned TB_TMO = 4;
`else
  localparam int unsigned TB_TMO = 255;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] blen;
  logic       fifo_empty;
  logic [7:0] fifo_rdata;
  logic       rd_en;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready;
  logic       busy;
  logic       done;
  logic [7:0] count;
  logic       tmo;

  logic rnd_bit;
  logic rand_mode;
  logic ready_fix;

  int         tests = 0;
  int         fails = 0;
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  int         outst;
  int         xfer_total = 0;
  logic [7:0] fifo_mem [64];
  logic [7:0] exp_q [$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  typedef struct {
    int len;
    int nwords;
    bit rnd;
    int exp_cnt;
  } vec_t;
  vec_t vecs [6];

  always #5 clk = ~clk;

  fifo_rd_ctrl #(
    .WIDTH  (8),
    .LEN_W  (8),
    .TIMEOUT(TB_TMO)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .burst_len_i (blen),
    .fifo_empty_i(fifo_empty),
    .fifo_rdata_i(fifo_rdata),
    .fifo_rd_en_o(rd_en),
    .m_valid_o   (m_valid),
    .m_data_o    (m_data),
    .m_ready_i   (m_ready),
    .busy_o      (busy),
    .done_o      (done),
    .count_o     (count),
    .timeout_o   (tmo)
  );

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign m_ready    = rand_mode ? rnd_bit : ready_fix;

  // Synchronous-read FIFO, flushed by the same reset as the controller.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr     <= wr_ptr;
      fifo_rdata <= '0;
    end else if (rd_en && (wr_ptr != rd_ptr)) begin
      fifo_rdata <= fifo_mem[rd_ptr % 64];
      rd_ptr     <= rd_ptr + 1;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      outst <= 0;
    end else begin
      outst <= outst + ((rd_en && !fifo_empty) ? 1 : 0) - ((m_valid && m_ready) ? 1 : 0);
    end
  end

  always @(posedge clk) rnd_bit <= 1'($urandom_range(0, 1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fifo_write(input logic [7:0] d);
    fifo_mem[wr_ptr % 64] = d;
    wr_ptr = wr_ptr + 1;
    exp_q.push_back(d);
  endtask

  task automatic monitor();
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      check("rd_en_while_empty", 32'(rd_en && fifo_empty), 0);
      check("outstanding_le3", 32'(outst <= 3), 1);
      if (prev_stall) begin
        check("hold_valid", 32'(m_valid), 1);
        check("hold_data", 32'(m_data), 32'(prev_data));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_unexpected: actual=%0h required=none", m_data);
        end else begin
          check("sb_data", 32'(m_data), 32'(exp_q.pop_front()));
        end
        xfer_total++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_en"},   32'(rd_en),   0);
    check({tag, "_valid"},   32'(m_valid), 0);
    check({tag, "_busy"},    32'(busy),    0);
    check({tag, "_done"},    32'(done),    0);
    check({tag, "_timeout"}, 32'(tmo),     0);
    check({tag, "_data"},    32'(m_data),  0);
    check({tag, "_count"},   32'(count),   0);
  endtask

  // start_i sampled at edge 0, FIFO read at edge 1, word visible after edge 2.
  task automatic lat_burst(input int n, input logic [7:0] base);
    bit seen;
    for (int i = 0; i < n; i++) fifo_write(base + 8'(i));
    ready_fix = 1'b1;
    start = 1'b1;
    blen  = 8'(n);
    tick();
    start = 1'b0;
    blen  = 8'hFF;
    check("lat_rd_en", 32'(rd_en), 1);
    check("lat_busy", 32'(busy), 1);
    check("lat_valid_c0", 32'(m_valid), 0);
    tick();
    check("lat_valid_c1", 32'(m_valid), 0);
    for (int i = 0; i < n; i++) begin
      tick();
      check("lat_valid", 32'(m_valid), 1);
      check("lat_data", 32'(m_data), 32'(base + 8'(i)));
    end
    wait_done(50, seen);
    check("lat_done_seen", 32'(seen), 1);
    check("lat_count", 32'(count), 32'(n));
    tick();
    check("lat_done_pulse", 32'(done), 0);
  endtask

  initial begin
    bit seen;
    int base;

    rst = 1'b1; start = 1'b0; blen = '0; ready_fix = 1'b1; rand_mode = 1'b0;
    vecs[0] = '{4, 4, 1'b0, 4};
    vecs[1] = '{1, 1, 1'b0, 1};
    vecs[2] = '{3, 3, 1'b1, 3};
    vecs[3] = '{0, 0, 1'b0, 0};
    vecs[4] = '{8, 8, 1'b1, 8};
    vecs[5] = '{5, 5, 1'b1, 5};

    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();
    check("idle_after_reset", 32'(busy), 0);

    lat_burst(4, 8'h11);

    // Zero-length burst: straight to DONE, no reads.
    start = 1'b1;
    blen  = 8'd0;
    tick();
    start = 1'b0;
    check("zero_done", 32'(done), 1);
    check("zero_rd_en", 32'(rd_en), 0);
    check("zero_count", 32'(count), 0);
    check("zero_busy", 32'(busy), 0);
    tick();
    check("zero_done_pulse", 32'(done), 0);

    for (int v = 0; v < 6; v++) begin
      for (int w = 0; w < vecs[v].nwords; w++) fifo_write(8'(v * 16 + w + 1));
      rand_mode = vecs[v].rnd;
      start = 1'b1;
      blen  = 8'(vecs[v].len);
      tick();
      start = 1'b0;
      blen  = 8'hFF;
      wait_done(300, seen);
      rand_mode = 1'b0;
      check($sformatf("vec%0d_done_seen", v), 32'(seen), 1);
      check($sformatf("vec%0d_count", v), 32'(count), 32'(vecs[v].exp_cnt));
      check($sformatf("vec%0d_timeout", v), 32'(tmo), 0);
      tick();
      check($sformatf("vec%0d_done_pulse", v), 32'(done), 0);
      check($sformatf("vec%0d_sb_drained", v), 32'(exp_q.size()), 0);
    end

    // Backpressure with a start_i pulse while busy that must be ignored.
    for (int i = 0; i < 8; i++) fifo_write(8'h21 + 8'(i));
    start = 1'b1;
    blen  = 8'd8;
    tick();
    start = 1'b0;
    tick();
    tick();
    ready_fix = 1'b0;
    for (int i = 0; i < 10; i++) begin
      start = (i == 3);
      blen  = 8'd1;
      tick();
      if (i == 5) check("bp_no_read_when_full", 32'(rd_en), 0);
    end
    start = 1'b0;
    ready_fix = 1'b1;
    wait_done(100, seen);
    check("bp_done_seen", 32'(seen), 1);
    check("bp_count", 32'(count), 8);
    tick();

`ifdef FIFO_RD_CTRL_TIMEOUT_EN
    fifo_write(8'h41);
    start = 1'b1;
    blen  = 8'd3;
    tick();
    start = 1'b0;
    wait_done(50, seen);
    check("tmo_done_seen", 32'(seen), 1);
    check("tmo_count", 32'(count), 1);
    check("tmo_flag", 32'(tmo), 1);
    tick();
    check("tmo_flag_held", 32'(tmo), 1);
    start = 1'b1;
    blen  = 8'd0;
    tick();
    start = 1'b0;
    check("tmo_flag_cleared", 32'(tmo), 0);
    tick();
`else
    fifo_write(8'h31);
    fifo_write(8'h32);
    start = 1'b1;
    blen  = 8'd5;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("empty_still_busy", 32'(busy), 1);
    check("empty_count_partial", 32'(count), 2);
    for (int i = 0; i < 3; i++) begin
      fifo_write(8'h33 + 8'(i));
      tick();
    end
    wait_done(50, seen);
    check("empty_done_seen", 32'(seen), 1);
    check("empty_count", 32'(count), 5);
    tick();
`endif

    // Reset mid-burst after two words have gone downstream.
    for (int i = 0; i < 6; i++) fifo_write(8'h51 + 8'(i));
    start = 1'b1;
    blen  = 8'd6;
    tick();
    start = 1'b0;
    base = xfer_total;
    for (int i = 0; i < 40; i++) begin
      if (xfer_total - base >= 2) break;
      tick();
    end
    check("rst_two_words_seen", 32'(xfer_total - base >= 2), 1);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    exp_q.delete();
    tick();
    rst = 1'b0;
    check("midrst_idle", 32'(busy), 0);
    lat_burst(1, 8'h11);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_rd_ctrl.md
FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: data word width, equal to the attached FIFO's WIDTH.
REQ-002 The block SHALL have parameter LEN_W, default 8: width of the burst length and the delivered count.
REQ-003 The block SHALL have parameter TIMEOUT, default 255: number of empty cycles that aborts a burst (only used when FIFO_RD_CTRL_TIMEOUT_EN is defined).
REQ-004 clk_i  input  1: the only clock; everything is sampled on its rising edge.
REQ-005 rst_i  input  1: reset, asynchronous, active-high.
REQ-006 start_i  input  1: burst request, sampled in IDLE only.
REQ-007 burst_len_i  input  LEN_W: number of words to drain, captured with start_i.
REQ-008 fifo_empty_i  input  1: FIFO empty flag.
REQ-009 fifo_rdata_i  input  WIDTH: FIFO read data, valid on the cycle after the read.
REQ-010 fifo_rd_en_o  output  1: FIFO read strobe.
REQ-011 m_valid_o  output  1: downstream word valid.
REQ-012 m_data_o  output  WIDTH: downstream word.
REQ-013 m_ready_i  input  1: downstream accepts the word.
REQ-014 busy_o  output  1: a burst is in progress.
REQ-015 done_o  output  1: one-cycle pulse at burst end.
REQ-016 count_o  output  LEN_W: words delivered downstream in the current or last burst.
REQ-017 timeout_o  output  1: the last burst was aborted by timeout.

Function
REQ-018 The FSM SHALL have four states: IDLE, READ, DRAIN, DONE.
- IDLE→READ on start_i with burst_len_i≠0.
- IDLE→DONE on start_i with burst_len_i=0.
- READ→DRAIN once burst_len_i reads have been issued.
- DRAIN→DONE once the buffer is empty and no read is in flight.
- DONE→IDLE unconditionally.
REQ-019 On leaving IDLE, the block SHALL capture burst_len_i, clear count_o and clear timeout_o.
REQ-020 fifo_rd_en_o SHALL be 1 only when all of the following hold: state is READ, fifo_empty_i=0, issued<len, and (buffered+inflight)<3.
REQ-021 fifo_rd_en_o SHALL NOT depend combinationally on m_ready_i, and SHALL never assert while fifo_empty_i=1.
REQ-022 Data read on cycle N SHALL be written into a 3-entry in-order skid buffer on cycle N+1.
REQ-023 m_valid_o SHALL equal (buffer nonempty); m_data_o SHALL be the buffer head.
REQ-024 Once m_valid_o is asserted, m_valid_o and m_data_o SHALL hold stable until m_valid_o&&m_ready_i.
REQ-025 On each transfer (m_valid_o&&m_ready_i), count_o SHALL increment by one; it saturates never (maximum equals len).
REQ-026 Buffer write and pop in the same cycle SHALL keep occupancy unchanged.
REQ-027 With the FIFO nonempty and m_ready_i=1 throughout, throughput SHALL be 1 word/cycle.
REQ-028 First-word latency SHALL be: start_i at cycle 0 → fifo_rd_en_o at cycle 1 → m_valid_o at cycle 2.
REQ-029 busy_o SHALL be 1 in READ and DRAIN.
REQ-030 done_o SHALL be 1 in DONE only.
REQ-031 start_i while busy SHALL be ignored.

Reset
REQ-032 While rst_i=1, the block SHALL asynchronously clear:
- FSM to IDLE;
- fifo_rd_en_o, m_valid_o, busy_o, done_o, timeout_o to 0;
- m_data_o, count_o, issued count, occupancy, inflight to 0.
REQ-033 Reset mid-burst SHALL discard buffered and in-flight words; the first cycle after release is IDLE.

Configuration
REQ-034 With FIFO_RD_CTRL_TIMEOUT_EN defined, a counter in READ SHALL:
- increment each cycle fifo_empty_i=1 with issued<len;
- clear on any fifo_rd_en_o.
REQ-035 With FIFO_RD_CTRL_TIMEOUT_EN defined, when the counter reaches TIMEOUT, the FSM SHALL go to DRAIN and set timeout_o.
REQ-036 timeout_o SHALL hold until the next accepted start_i.
REQ-037 Without FIFO_RD_CTRL_TIMEOUT_EN, no timeout logic SHALL exist, timeout_o SHALL be tied 0, and READ waits indefinitely.

Structure
REQ-038 Package fifo_pkg SHALL hold the FSM state typedef (IDLE/READ/DRAIN/DONE) and the skid depth constant (3).
REQ-039 The 3-entry buffer SHALL be the sub-module fifo_rd_skid, with ports push, push_data, pop, head, nonempty, and occupancy.

Verification
REQ-040 Basic burst: FIFO holds 0x11..0x14, burst_len=4, m_ready_i=1 → m_data_o 0x11,0x12,0x13,0x14 on cycles 2–5; done_o pulse; count_o=4.
REQ-041 Backpressure: m_ready_i=0 for 10 cycles mid-burst (len=8) → at most 3 reads outstanding, m_data_o stable, no loss/reorder, count_o=8.
REQ-042 Empty FIFO: FIFO holds 2 words, len=5 → fifo_rd_en_o never asserts with fifo_empty_i=1; burst completes after 3 more words are written.
REQ-043 Zero length: start_i with burst_len=0 → done_o next cycle, no fifo_rd_en_o, count_o=0.
REQ-044 Reset mid-burst: rst_i asserted after 2 of 6 words → all outputs 0 immediately; next start_i with len=1 behaves as REQ-040.
REQ-045 Timeout (macro on, TIMEOUT=4): FIFO holds 1 word, len=3 → 1 word delivered, timeout_o=1, done_o pulse, count_o=1.
